// File: rtl/sd_fifo_head_mc.sv
// rtl/sd_fifo_head_mc.sv - multi-channel FIFO head controller sharing one memory write port
// Round-robin arbitration among producer channels, each with its own write, commit pointer and usage.
module sd_fifo_head_mc #(
    parameter int channels = 4,
    parameter int depth    = 64,
    parameter int asz      = $clog2(depth),
    parameter int csz      = $clog2(channels),
    parameter int commit   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [channels-1:0]         c_srdy,
    output logic [channels-1:0]         c_drdy,
    input  logic [channels-1:0]         c_commit,
    input  logic [channels-1:0]         c_abort,
    input  logic [channels*asz-1:0]     bound_low,
    input  logic [channels*asz-1:0]     bound_high,
    input  logic [channels*asz-1:0]     rdptr,
    output logic [channels*asz-1:0]     cur_wrptr,
    output logic [channels*asz-1:0]     com_wrptr,
    output logic [channels*(asz+1)-1:0] usage,
    output logic                        mem_we,
    output logic [asz-1:0]              mem_addr,
    output logic [csz-1:0]              mem_chan
);

    logic [asz-1:0]      bl     [channels];
    logic [asz-1:0]      bh     [channels];
    logic [asz-1:0]      rd     [channels];
    logic [asz-1:0]      p1     [channels];
    logic [asz-1:0]      cur_q  [channels];
    logic [asz-1:0]      cur_d  [channels];
    logic [asz-1:0]      com_q  [channels];
    logic [asz-1:0]      com_d  [channels];
    logic [channels-1:0] full;
    logic [channels-1:0] elig;
    logic [channels-1:0] grant;
    logic [channels-1:0] accept;
    logic [csz-1:0]      last_q;
    logic [csz-1:0]      last_d;
    logic [csz-1:0]      gidx;
    logic                gvalid;
    logic                fire;

    always_comb begin
        for (int i = 0; i < channels; i++) begin
            bl[i]   = bound_low[i*asz +: asz];
            bh[i]   = bound_high[i*asz +: asz];
            rd[i]   = rdptr[i*asz +: asz];
            p1[i]   = (cur_q[i] == bh[i]) ? bl[i] : cur_q[i] + asz'(1);
            full[i] = (p1[i] == rd[i]);
            elig[i] = c_srdy[i] & ~full[i] & ~((commit != 0) & c_abort[i]);
        end
    end

    // Search begins just after the last granted channel so every requester is served in turn.
    always_comb begin
        int idx;
        gvalid = 1'b0;
        gidx   = '0;
        idx    = 0;
        for (int k = 1; k <= channels; k++) begin
            idx = (int'(last_q) + k) % channels;
            if (!gvalid && elig[idx]) begin
                gvalid = 1'b1;
                gidx   = csz'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (gvalid) begin
            grant = {{(channels-1){1'b0}}, 1'b1} << gidx;
        end
    end

    assign fire     = enable & gvalid & ~reset;
    assign c_drdy   = fire ? grant : '0;
    assign mem_we   = fire;
    assign mem_addr = cur_q[gidx];
    assign mem_chan = gidx;
    assign last_d   = fire ? gidx : last_q;

    always_comb begin
        for (int i = 0; i < channels; i++) begin
            accept[i] = fire && (gidx == csz'(i));
        end
    end

    // Without commit support the committed pointer simply shadows the write pointer.
    always_comb begin
        for (int i = 0; i < channels; i++) begin
            cur_d[i] = cur_q[i];
            com_d[i] = com_q[i];
            if (commit != 0) begin
                if (c_abort[i]) begin
                    cur_d[i] = com_q[i];
                end else begin
                    if (accept[i]) begin
                        cur_d[i] = p1[i];
                    end
                    if (c_commit[i]) begin
                        com_d[i] = accept[i] ? p1[i] : cur_q[i];
                    end
                end
            end else begin
                if (accept[i]) begin
                    cur_d[i] = p1[i];
                end
                com_d[i] = cur_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < channels; i++) begin
                cur_q[i] <= bl[i];
                com_q[i] <= bl[i];
            end
            last_q <= csz'(channels - 1);
        end else begin
            for (int i = 0; i < channels; i++) begin
                cur_q[i] <= cur_d[i];
                com_q[i] <= com_d[i];
            end
            last_q <= last_d;
        end
    end

    always_comb begin
        for (int i = 0; i < channels; i++) begin
            cur_wrptr[i*asz +: asz] = cur_q[i];
            com_wrptr[i*asz +: asz] = com_q[i];
        end
    end

    // Occupancy of the committed region; the wrapped case adds back the region size.
    always_comb begin
        logic [asz:0] size;
        size = '0;
        for (int i = 0; i < channels; i++) begin
            size = {1'b0, bh[i]} - {1'b0, bl[i]} + (asz+1)'(1);
            if (com_q[i] >= rd[i]) begin
                usage[i*(asz+1) +: (asz+1)] = {1'b0, com_q[i]} - {1'b0, rd[i]};
            end else begin
                usage[i*(asz+1) +: (asz+1)] = size - ({1'b0, rd[i]} - {1'b0, com_q[i]});
            end
        end
    end

endmodule

// File: tb/tb_sd_fifo_head_mc.sv
// tb/tb_sd_fifo_head_mc.sv - randomized and directed bench for sd_fifo_head_mc, both commit modes
module tb_sd_fifo_head_mc;
    localparam int CH = 4, DEPTH = 64, ASZ = 6, CSZ = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, enable;
    logic [CH-1:0]        c_srdy, c_commit, c_abort;
    logic [CH*ASZ-1:0]    bound_low, bound_high;
    logic [CH*ASZ-1:0]    rdptr     [2];
    logic [CH-1:0]        c_drdy    [2];
    logic [CH*ASZ-1:0]    cur_wrptr [2];
    logic [CH*ASZ-1:0]    com_wrptr [2];
    logic [CH*(ASZ+1)-1:0] usage    [2];
    logic                 mem_we    [2];
    logic [ASZ-1:0]       mem_addr  [2];
    logic [CSZ-1:0]       mem_chan  [2];

    sd_fifo_head_mc #(.channels(CH), .depth(DEPTH), .commit(0)) u_dut_nc (
        .clk(clk), .reset(reset), .enable(enable), .c_srdy(c_srdy), .c_drdy(c_drdy[0]),
        .c_commit(c_commit), .c_abort(c_abort), .bound_low(bound_low), .bound_high(bound_high),
        .rdptr(rdptr[0]), .cur_wrptr(cur_wrptr[0]), .com_wrptr(com_wrptr[0]), .usage(usage[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_chan(mem_chan[0]));

    sd_fifo_head_mc #(.channels(CH), .depth(DEPTH), .commit(1)) u_dut_c (
        .clk(clk), .reset(reset), .enable(enable), .c_srdy(c_srdy), .c_drdy(c_drdy[1]),
        .c_commit(c_commit), .c_abort(c_abort), .bound_low(bound_low), .bound_high(bound_high),
        .rdptr(rdptr[1]), .cur_wrptr(cur_wrptr[1]), .com_wrptr(com_wrptr[1]), .usage(usage[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_chan(mem_chan[1]));

    int bl [CH] = '{0, 16, 32, 40};
    int bh [CH] = '{7, 31, 35, 63};
    int m_cur [2][CH];
    int m_com [2][CH];
    int m_rd  [2][CH];
    int m_last [2];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int i, input int p);
        return bl[i] + ((p - bl[i]) + 1) % (bh[i] - bl[i] + 1);
    endfunction

    function automatic int occ(input int i, input int hi, input int r);
        int sz;
        sz = bh[i] - bl[i] + 1;
        return (hi - r + sz) % sz;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < CH; i++) begin
                m_cur[d][i] = bl[i];
                m_com[d][i] = bl[i];
                m_rd[d][i]  = bl[i];
            end
            m_last[d] = CH - 1;
        end
    endtask

    // The tail consumes committed entries only.
    task automatic tail_rand(input int pct);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(99) < pct && occ(i, m_com[d][i], m_rd[d][i]) > 0)
                    m_rd[d][i] = nxt(i, m_rd[d][i]);
            end
        end
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < CH; i++)
                rdptr[d][i*ASZ +: ASZ] = ASZ'(m_rd[d][i]);
        #1;
        for (int d = 0; d < 2; d++) begin
            int  j, c, old;
            bit  found, we, acc;
            found = 0;
            j = 0;
            for (int k = 1; k <= CH; k++) begin
                c = (m_last[d] + k) % CH;
                if (!found && c_srdy[c] && nxt(c, m_cur[d][c]) != m_rd[d][c] && !(d == 1 && c_abort[c])) begin
                    found = 1;
                    j = c;
                end
            end
            we = !reset && enable && found;
            check($sformatf("d%0d mem_we", d), 64'(mem_we[d]), 64'(we));
            check($sformatf("d%0d c_drdy", d), 64'(c_drdy[d]), we ? 64'(1) << j : 64'(0));
            if (we) begin
                check($sformatf("d%0d mem_addr", d), 64'(mem_addr[d]), 64'(m_cur[d][j]));
                check($sformatf("d%0d mem_chan", d), 64'(mem_chan[d]), 64'(j));
            end
            for (int i = 0; i < CH; i++) begin
                check($sformatf("d%0d cur%0d", d, i), 64'(cur_wrptr[d][i*ASZ +: ASZ]), 64'(m_cur[d][i]));
                check($sformatf("d%0d com%0d", d, i), 64'(com_wrptr[d][i*ASZ +: ASZ]), 64'(m_com[d][i]));
                check($sformatf("d%0d usage%0d", d, i), 64'(usage[d][i*(ASZ+1) +: (ASZ+1)]),
                      64'(occ(i, m_com[d][i], m_rd[d][i])));
            end
            if (!reset) begin
                for (int i = 0; i < CH; i++) begin
                    acc = we && (j == i);
                    old = m_cur[d][i];
                    if (d == 1) begin
                        if (c_abort[i]) m_cur[d][i] = m_com[d][i];
                        else begin
                            if (acc) m_cur[d][i] = nxt(i, old);
                            if (c_commit[i]) m_com[d][i] = acc ? nxt(i, old) : old;
                        end
                    end else begin
                        if (acc) m_cur[d][i] = nxt(i, old);
                        m_com[d][i] = m_cur[d][i];
                    end
                end
                if (we) m_last[d] = j;
            end
        end
        if (reset) model_reset();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0;
        c_srdy = '0; c_commit = '0; c_abort = '0;
        for (int i = 0; i < CH; i++) begin
            bound_low[i*ASZ +: ASZ]  = ASZ'(bl[i]);
            bound_high[i*ASZ +: ASZ] = ASZ'(bh[i]);
        end
        repeat (3) @(negedge clk);
        model_reset();
        c_srdy = 4'b1111; enable = 1'b1;
        do_reset();

        // channel 0 fills its 8-entry region, stalls, then wraps once the tail moves
        c_srdy = 4'b0001;
        repeat (9) step();
        check("ch0_full_ptr", 64'(cur_wrptr[0][ASZ-1:0]), 64'd7);
        m_rd[0][0] = 1; m_rd[1][0] = 1;
        step();
        check("ch0_wrap_ptr", 64'(cur_wrptr[0][ASZ-1:0]), 64'd0);

        // all channels request; enable gap must not disturb the rotation
        do_reset();
        c_srdy = 4'b1111;
        repeat (8) begin tail_rand(100); step(); end
        enable = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        repeat (8) begin tail_rand(100); step(); end

        // commit five words on channel 1, then abort three uncommitted ones
        do_reset();
        c_srdy = 4'b0010;
        repeat (4) step();
        c_commit = 4'b0010;
        step();
        c_commit = '0; c_srdy = '0;
        check("commit_ptr", 64'(com_wrptr[1][ASZ +: ASZ]), 64'd21);
        check("commit_usage", 64'(usage[1][(ASZ+1) +: (ASZ+1)]), 64'd5);
        c_srdy = 4'b0010;
        repeat (3) step();
        c_srdy = '0; c_abort = 4'b0010;
        step();
        c_abort = '0;
        check("abort_ptr", 64'(cur_wrptr[1][ASZ +: ASZ]), 64'd21);
        check("abort_usage", 64'(usage[1][(ASZ+1) +: (ASZ+1)]), 64'd5);

        // channel 2 fills and channel 3 keeps streaming
        do_reset();
        c_srdy = 4'b1100;
        repeat (8) step();
        check("ch2_full_ptr", 64'(cur_wrptr[0][2*ASZ +: ASZ]), 64'd35);
        check("ch3_ptr", 64'(cur_wrptr[0][3*ASZ +: ASZ]), 64'd45);

        // random traffic with a reset in the middle
        do_reset();
        for (int n = 0; n < 800; n++) begin
            c_srdy   = CH'($urandom);
            enable   = ($urandom_range(4) != 0);
            c_commit = CH'($urandom & $urandom);
            c_abort  = '0;
            for (int i = 0; i < CH; i++)
                if ($urandom_range(15) == 0) c_abort[i] = 1'b1;
            reset = (n == 400);
            tail_rand(40);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end
endmodule
